// File: rtl/baccarat_match_scheduler.sv
// ---------------------------------------------------------------------------
// baccarat_match_scheduler
//
// Sequences repeated baccarat hands into one match on top of the per-hand
// dealing state machine. Each hand is started by holding that machine's
// active-low reset for RST_CYCLES cycles. The win lights are then watched
// and player/dealer/tie results are tallied. A finished hand stays on
// display for HOLD_CYCLES cycles before the next hand. A match winner is
// declared when either side reaches WINS_TO_MATCH or MAX_ROUNDS hands
// have been played. A watchdog aborts the match if a hand shows no light
// within PLAY_TIMEOUT cycles.
//
// Ports
//   slow_clock        in   clock, rising edge
//   reset             in   synchronous, active-high
//   start             in   start/restart a match (honoured in IDLE/DONE only)
//   player_win_light  in   player light from hand state machine
//   dealer_win_light  in   dealer light from hand state machine
//   hand_resetb       out  active-low reset to hand state machine
//   busy              out  1 while a hand is being reset, played or held
//   round_count       out  hands completed this match
//   player_wins       out  player-won hands
//   dealer_wins       out  dealer-won hands
//   tie_count         out  tied hands
//   match_over        out  1 while in DONE
//   match_winner      out  10 player, 01 dealer, 11 tie, 00 none/abort
//   error             out  watchdog abort flag
// ---------------------------------------------------------------------------
module baccarat_match_scheduler #(
  parameter int WINS_TO_MATCH = 3,
  parameter int MAX_ROUNDS    = 9,
  parameter int RST_CYCLES    = 2,
  parameter int HOLD_CYCLES   = 4,
  parameter int PLAY_TIMEOUT  = 15
) (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic       start,
  input  logic       player_win_light,
  input  logic       dealer_win_light,
  output logic       hand_resetb,
  output logic       busy,
  output logic [3:0] round_count,
  output logic [3:0] player_wins,
  output logic [3:0] dealer_wins,
  output logic [3:0] tie_count,
  output logic       match_over,
  output logic [1:0] match_winner,
  output logic       error
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HAND_RST = 3'd1,
    S_PLAY     = 3'd2,
    S_HOLD     = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  // Last value of the shared cycle counter in each timed state.
  localparam logic [3:0] LP_RST_LAST  = 4'(RST_CYCLES - 1);
  localparam logic [3:0] LP_HOLD_LAST = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] LP_PLAY_LAST = 4'(PLAY_TIMEOUT - 1);
  localparam logic [3:0] LP_WINS      = 4'(WINS_TO_MATCH);
  localparam logic [3:0] LP_MAX       = 4'(MAX_ROUNDS);

  state_t     r_state, w_next;
  logic [3:0] r_cyc, w_cyc;
  logic [3:0] r_round, w_round;
  logic [3:0] r_player, w_player;
  logic [3:0] r_dealer, w_dealer;
  logic [3:0] r_tie, w_tie;
  logic [1:0] r_winner, w_winner;
  logic       r_error, w_error;
  logic       r_hand_resetb, w_hand_resetb;
  logic       r_busy, w_busy;
  logic       r_match_over, w_match_over;
  logic       w_any_light;

  assign w_any_light = player_win_light | dealer_win_light;

  // State register plus all registered outputs.
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cyc         <= '0;
      r_round       <= '0;
      r_player      <= '0;
      r_dealer      <= '0;
      r_tie         <= '0;
      r_winner      <= '0;
      r_error       <= 1'b0;
      r_hand_resetb <= 1'b0;
      r_busy        <= 1'b0;
      r_match_over  <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_cyc         <= w_cyc;
      r_round       <= w_round;
      r_player      <= w_player;
      r_dealer      <= w_dealer;
      r_tie         <= w_tie;
      r_winner      <= w_winner;
      r_error       <= w_error;
      r_hand_resetb <= w_hand_resetb;
      r_busy        <= w_busy;
      r_match_over  <= w_match_over;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_next   = r_state;
    w_cyc    = r_cyc;
    w_round  = r_round;
    w_player = r_player;
    w_dealer = r_dealer;
    w_tie    = r_tie;
    w_winner = r_winner;
    w_error  = r_error;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_next   = S_HAND_RST;
          w_cyc    = '0;
          w_round  = '0;
          w_player = '0;
          w_dealer = '0;
          w_tie    = '0;
          w_winner = '0;
          w_error  = 1'b0;
        end
      end
      S_HAND_RST: begin
        if (r_cyc == LP_RST_LAST) begin
          w_next = S_PLAY;
          w_cyc  = '0;
        end else begin
          w_cyc = r_cyc + 4'd1;
        end
      end
      S_PLAY: begin
        // A light on the final timeout cycle still counts as a result.
        if (w_any_light) begin
          w_round = r_round + 4'd1;
          if (player_win_light && dealer_win_light) w_tie = r_tie + 4'd1;
          else if (player_win_light)                w_player = r_player + 4'd1;
          else                                      w_dealer = r_dealer + 4'd1;
          w_next = S_HOLD;
          w_cyc  = '0;
        end else if (r_cyc == LP_PLAY_LAST) begin
          w_next   = S_DONE;
          w_cyc    = '0;
          w_error  = 1'b1;
          w_winner = 2'b00;
        end else begin
          w_cyc = r_cyc + 4'd1;
        end
      end
      S_HOLD: begin
        if (r_cyc == LP_HOLD_LAST) begin
          w_cyc = '0;
          if (r_player == LP_WINS || r_dealer == LP_WINS || r_round == LP_MAX) begin
            w_next = S_DONE;
            if (r_player > r_dealer)      w_winner = 2'b10;
            else if (r_player < r_dealer) w_winner = 2'b01;
            else                          w_winner = 2'b11;
          end else begin
            w_next = S_HAND_RST;
          end
        end else begin
          w_cyc = r_cyc + 4'd1;
        end
      end
      default: begin
        w_next = S_IDLE;
        w_cyc  = '0;
      end
    endcase
  end

  // Output decode from the upcoming state, so outputs are registered yet
  // aligned with the state they describe.
  always_comb begin
    w_hand_resetb = 1'b0;
    w_busy        = 1'b0;
    w_match_over  = 1'b0;
    case (w_next)
      S_HAND_RST: w_busy = 1'b1;
      S_PLAY, S_HOLD: begin
        w_hand_resetb = 1'b1;
        w_busy        = 1'b1;
      end
      S_DONE: begin
        w_hand_resetb = 1'b1;
        w_match_over  = 1'b1;
      end
      default: ;
    endcase
  end

  assign hand_resetb  = r_hand_resetb;
  assign busy         = r_busy;
  assign round_count  = r_round;
  assign player_wins  = r_player;
  assign dealer_wins  = r_dealer;
  assign tie_count    = r_tie;
  assign match_over   = r_match_over;
  assign match_winner = r_winner;
  assign error        = r_error;

endmodule
